// File: rtl/coin_acceptor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | coin_acceptor_if : sensor/accept inputs and coin strobe/status outputs   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface coin_acceptor_if;
  logic       nickel_sense;
  logic       dime_sense;
  logic       accept_en;
  logic [3:0] coin;
  logic       coin_valid;
  logic       reject;
  logic [3:0] fifo_count;
  logic [1:0] state;

  modport slave (
    input  nickel_sense, dime_sense, accept_en,
    output coin, coin_valid, reject, fifo_count, state
  );

  modport master (
    output nickel_sense, dime_sense, accept_en,
    input  coin, coin_valid, reject, fifo_count, state
  );
endinterface
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | coin_acceptor : debounced coin sensors -> event FIFO -> paced coin strobe|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  wire logic      clk_i,
  input  wire logic      rst_ni,
  coin_acceptor_if.slave bus
);
  localparam int         c_AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] c_DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] c_DEPTH    = 4'(FIFO_DEPTH);
  localparam logic [2:0] c_GAP_LAST = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;
  localparam logic [3:0] c_NICKEL   = 4'd5;
  localparam logic [3:0] c_DIME     = 4'd10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESENT = 2'b01,
    GAP     = 2'b10
  } state_e;

  logic [1:0]            sync1_q, sync2_q, deb_q;
  logic [3:0]            cnt_q [2];
  logic [1:0]            w_rise;
  logic [FIFO_DEPTH-1:0] mem_q;
  logic [c_AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [3:0]            count_q;
  logic                  reject_q;
  logic                  w_full, w_single, w_both, w_push, w_pop, w_reject;
  state_e                state_q, state_d;
  logic [2:0]            gap_q, gap_d;
  logic [3:0]            coin_q, coin_d;
  logic                  valid_q, valid_d;

  // Bit 0 is the nickel sensor, bit 1 the dime sensor throughout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q <= {bus.dime_sense, bus.nickel_sense};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == c_DEB_LAST) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // A rise is the edge on which the debounced level is about to go 0 -> 1.
  always_comb begin
    w_rise = '0;
    for (int i = 0; i < 2; i++) begin
      w_rise[i] = sync2_q[i] & ~deb_q[i] & (cnt_q[i] == c_DEB_LAST);
    end
  end

  assign w_full   = (count_q == c_DEPTH);
  assign w_single = ^w_rise;
  assign w_both   = &w_rise;
  assign w_push   = w_single & (~w_full | w_pop);
  assign w_reject = w_both | (w_single & w_full & ~w_pop);

  // FIFO entries store 1 for a dime, 0 for a nickel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= w_rise[1];
        wr_ptr_q        <= wr_ptr_q + c_AW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_AW'(1);
      end
      count_q  <= count_q + {3'd0, w_push} - {3'd0, w_pop};
      reject_q <= w_reject;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gap_q   <= '0;
      coin_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      coin_q  <= coin_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    coin_d  = '0;
    valid_d = 1'b0;
    w_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count_q != 4'd0) && bus.accept_en) begin
          w_pop   = 1'b1;
          coin_d  = mem_q[rd_ptr_q] ? c_DIME : c_NICKEL;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        gap_d   = '0;
        state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_q == c_GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.coin       = coin_q;
  assign bus.coin_valid = valid_q;
  assign bus.reject     = reject_q;
  assign bus.fifo_count = count_q;
  assign bus.state      = state_q;
endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_coin_acceptor : vector table, corner sequences and random vs model    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_coin_acceptor;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int GAP   = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coin_acceptor_if bus ();

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH     (DEPTH),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference: raw samples since reset, debounce as "last DEB sync samples all
  // differ", a queue of coin values and a countdown of non-idle cycles.
  logic [1:0] raw_h[$];
  logic [1:0] m_d;
  int         q[$];
  int         m_busy, m_coin, m_cnt, m_state, m_valid, m_rej;

  function automatic void model_reset();
    raw_h.delete();
    q.delete();
    m_d = '0; m_busy = 0; m_coin = 0; m_cnt = 0; m_state = 0; m_valid = 0; m_rej = 0;
  endfunction

  function automatic bit s_at(input int k, input int i);
    logic [1:0] v;
    if (k < 2) return 1'b0;
    v = raw_h[k-2];
    return v[i];
  endfunction

  function automatic void model_step(input logic n, input logic dm, input logic ae);
    logic [1:0] rise;
    bit         flip, pop;
    int         k, head;
    raw_h.push_back({dm, n});
    k    = raw_h.size() - 1;
    rise = '0;
    head = 0;
    for (int i = 0; i < 2; i++) begin
      flip = 1'b1;
      for (int j = 0; j < DEB; j++) if (s_at(k - j, i) == m_d[i]) flip = 1'b0;
      if (flip) begin
        if (!m_d[i]) rise[i] = 1'b1;
        m_d[i] = ~m_d[i];
      end
    end
    pop = (m_busy == 0) && (q.size() > 0) && ae;
    if (pop) head = q.pop_front();
    m_rej = 0;
    if (rise == 2'b11) m_rej = 1;
    else if (rise != 2'b00) begin
      if (q.size() < DEPTH) q.push_back(rise[1] ? 10 : 5);
      else m_rej = 1;
    end
    if (pop) begin
      m_valid = 1; m_coin = head; m_busy = 1 + GAP; m_state = 1;
    end else begin
      m_valid = 0; m_coin = 0;
      if (m_busy > 0) m_busy--;
      m_state = (m_busy == 0) ? 0 : 2;
    end
    m_cnt = q.size();
  endfunction

  int cyc, n_valid, n_rej, max_cnt, n_present, n_gap;
  int got[$];
  int vcyc[$];

  function automatic void clear_log();
    n_valid = 0; n_rej = 0; max_cnt = 0; n_present = 0; n_gap = 0;
    got.delete();
    vcyc.delete();
  endfunction

  task automatic tick(input logic n, input logic dm, input logic ae);
    bus.nickel_sense = n;
    bus.dime_sense   = dm;
    bus.accept_en    = ae;
    @(posedge clk);
    model_step(n, dm, ae);
    #1;
    cyc++;
    chk("coin",       int'(bus.coin),       m_coin);
    chk("coin_valid", int'(bus.coin_valid), m_valid);
    chk("reject",     int'(bus.reject),     m_rej);
    chk("fifo_count", int'(bus.fifo_count), m_cnt);
    chk("state",      int'(bus.state),      m_state);
    if (bus.coin_valid) begin
      n_valid++;
      got.push_back(int'(bus.coin));
      vcyc.push_back(cyc);
    end
    if (bus.reject) n_rej++;
    if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
    if (bus.state == 2'b01) n_present++;
    if (bus.state == 2'b10) n_gap++;
  endtask

  task automatic hold(input logic n, input logic dm, input logic ae, input int cycles);
    for (int i = 0; i < cycles; i++) tick(n, dm, ae);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_coin",  int'(bus.coin),       0);
    chk("rst_valid", int'(bus.coin_valid), 0);
    chk("rst_reject", int'(bus.reject),    0);
    chk("rst_count", int'(bus.fifo_count), 0);
    chk("rst_state", int'(bus.state),      0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       n;
    logic       dm;
    logic       ae;
    logic       ev;
    logic [3:0] ec;
    logic [3:0] ecnt;
    logic       erej;
    logic [1:0] est;
  } vec_t;

  vec_t tbl[16];
  int   hn, hd, found;
  logic rn, rd, rae;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single nickel held 10 cycles; row k is the edge k after the sensor rises.
    for (int k = 0; k < 16; k++) begin
      tbl[k].n    = (k < 10);
      tbl[k].dm   = 1'b0;
      tbl[k].ae   = 1'b1;
      tbl[k].ev   = 1'b0;
      tbl[k].ec   = 4'd0;
      tbl[k].ecnt = 4'd0;
      tbl[k].erej = 1'b0;
      tbl[k].est  = 2'b00;
    end
    tbl[5].ecnt = 4'd1;
    tbl[6].ev   = 1'b1;
    tbl[6].ec   = 4'd5;
    tbl[6].est  = 2'b01;
    tbl[7].est  = 2'b10;

    bus.nickel_sense = 1'b0;
    bus.dime_sense   = 1'b0;
    bus.accept_en    = 1'b1;
    cyc = 0;
    clear_log();
    model_reset();
    do_reset();

    for (int k = 0; k < 16; k++) begin
      tick(tbl[k].n, tbl[k].dm, tbl[k].ae);
      chk($sformatf("tbl%0d_valid", k), int'(bus.coin_valid), int'(tbl[k].ev));
      chk($sformatf("tbl%0d_coin", k),  int'(bus.coin),       int'(tbl[k].ec));
      chk($sformatf("tbl%0d_count", k), int'(bus.fifo_count), int'(tbl[k].ecnt));
      chk($sformatf("tbl%0d_rej", k),   int'(bus.reject),     int'(tbl[k].erej));
      chk($sformatf("tbl%0d_state", k), int'(bus.state),      int'(tbl[k].est));
    end

    // Glitch of 3 cycles on the dime sensor
    clear_log();
    hold(1'b0, 1'b1, 1'b1, 3);
    hold(1'b0, 1'b0, 1'b1, 10);
    chk("glitch_valid", n_valid, 0);
    chk("glitch_count", max_cnt, 0);

    // Five dimes against backpressure, then drain
    clear_log();
    for (int i = 0; i < 5; i++) begin
      hold(1'b0, 1'b1, 1'b0, 7);
      hold(1'b0, 1'b0, 1'b0, 7);
    end
    chk("burst_max_count", max_cnt, 4);
    chk("burst_reject", n_rej, 1);
    chk("burst_no_valid", n_valid, 0);
    clear_log();
    hold(1'b0, 1'b0, 1'b1, 16);
    chk("drain_n", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk("drain_coin", got[i], 10);
    for (int i = 1; i < vcyc.size(); i++) chk("drain_spacing", vcyc[i] - vcyc[i-1], 2 + GAP);
    chk("drain_count", int'(bus.fifo_count), 0);

    // Both sensors rising together
    clear_log();
    hold(1'b1, 1'b1, 1'b1, 8);
    hold(1'b0, 1'b0, 1'b1, 8);
    chk("simul_reject", n_rej, 1);
    chk("simul_count", max_cnt, 0);
    chk("simul_valid", n_valid, 0);

    // Mixed order nickel, dime, nickel
    clear_log();
    hold(1'b1, 1'b0, 1'b1, 8);
    hold(1'b0, 1'b0, 1'b1, 8);
    hold(1'b0, 1'b1, 1'b1, 8);
    hold(1'b0, 1'b0, 1'b1, 8);
    hold(1'b1, 1'b0, 1'b1, 8);
    hold(1'b0, 1'b0, 1'b1, 10);
    chk("mixed_n", got.size(), 3);
    if (got.size() == 3) begin
      chk("mixed_0", got[0], 5);
      chk("mixed_1", got[1], 10);
      chk("mixed_2", got[2], 5);
    end
    chk("mixed_present", n_present, 3);
    chk("mixed_gap", n_gap, 3 * GAP);

    // Reset while presenting with two coins still queued
    clear_log();
    for (int i = 0; i < 3; i++) begin
      hold(1'b0, 1'b1, 1'b0, 7);
      hold(1'b0, 1'b0, 1'b0, 7);
    end
    found = 0;
    for (int i = 0; i < 6 && found == 0; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (bus.state == 2'b01) found = 1;
    end
    chk("midrst_present", found, 1);
    chk("midrst_queued", int'(bus.fifo_count), 2);
    do_reset();
    clear_log();
    hold(1'b0, 1'b0, 1'b1, 20);
    chk("postrst_valid", n_valid, 0);
    chk("postrst_count", int'(bus.fifo_count), 0);

    // Nickel held high through reset release yields exactly one coin
    bus.nickel_sense = 1'b1;
    do_reset();
    clear_log();
    hold(1'b1, 1'b0, 1'b1, 12);
    hold(1'b0, 1'b0, 1'b1, 6);
    chk("held_n", got.size(), 1);
    if (got.size() == 1) chk("held_coin", got[0], 5);

    // Randomised sensors and accept_en against the reference
    do_reset();
    clear_log();
    hn = 0; hd = 0; rn = 1'b0; rd = 1'b0; rae = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if (hn == 0) begin
        rn = ~rn;
        hn = rn ? int'($urandom_range(2, 10)) : int'($urandom_range(1, 12));
      end
      if (hd == 0) begin
        rd = ~rd;
        hd = rd ? int'($urandom_range(2, 10)) : int'($urandom_range(1, 12));
      end
      if ($urandom_range(0, 15) == 0) begin
        rd = rn;
        hd = hn;
      end
      if ($urandom_range(0, 9) == 0) rae = ~rae;
      hn--;
      hd--;
      tick(rn, rd, rae);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
